// File: rtl/nou_bu_pkg.sv
// Shared buffer-unit types: retire record layout, field widths and counter defaults.
package nou_bu_pkg;

  localparam int unsigned NOU_SID_WIDTH         = 8;
  localparam int unsigned NOU_RSP_TYPE_ID_WIDTH = 3;
  localparam int unsigned NOU_BUF_ID_WIDTH      = 6;
  localparam int unsigned NOU_ERR_CODE_WIDTH    = 4;
  localparam int unsigned NOU_BUF_RM_WIDTH      = 8;

  localparam int unsigned BU_RCNT_W_DEF = 16;
  localparam int unsigned BU_ECNT_W_DEF = 8;

  typedef struct packed {
    logic [NOU_SID_WIDTH-1:0]         sid;
    logic [NOU_RSP_TYPE_ID_WIDTH-1:0] rtype;
    logic [NOU_BUF_ID_WIDTH-1:0]      buf_id;
    logic                             status;
    logic [NOU_ERR_CODE_WIDTH-1:0]    err_code;
    logic [NOU_BUF_RM_WIDTH-1:0]      rm;
  } bu_rtr_rec_t;

  typedef enum logic {
    RS_EMPTY = 1'b0,
    RS_FULL  = 1'b1
  } bu_rtr_state_e;

endpackage

// File: rtl/bu_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo N.
module bu_rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int unsigned w_idx;
  logic        w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = (32'(ptr) + k) % N;
      if (!w_found && req[w_idx[IW-1:0]]) begin
        w_found                 = 1'b1;
        grant[w_idx[IW-1:0]]    = 1'b1;
        grant_idx               = w_idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bu_retire_arb.sv
// Retire arbiter: round-robin selection of requester records into one output register
// stage with valid/ready handshake, plus retire and saturating error counters.
module bu_retire_arb
  import nou_bu_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned RCNT_W = BU_RCNT_W_DEF,
  parameter int unsigned ECNT_W = BU_ECNT_W_DEF
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [NREQ-1:0]                       req_vld,
  output logic [NREQ-1:0]                       req_rdy,
  input  logic [NREQ*NOU_SID_WIDTH-1:0]         req_sid,
  input  logic [NREQ*NOU_RSP_TYPE_ID_WIDTH-1:0] req_rtype,
  input  logic [NREQ*NOU_BUF_ID_WIDTH-1:0]      req_buf_id,
  input  logic [NREQ-1:0]                       req_status,
  input  logic [NREQ*NOU_ERR_CODE_WIDTH-1:0]    req_err_code,
  input  logic [NREQ*NOU_BUF_RM_WIDTH-1:0]      req_rm,
  output logic                                  rsp_vld,
  input  logic                                  rsp_rdy,
  output logic [NOU_SID_WIDTH-1:0]              rsp_sid,
  output logic [NOU_RSP_TYPE_ID_WIDTH-1:0]      rsp_rtype,
  output logic [NOU_BUF_ID_WIDTH-1:0]           rsp_buf_id,
  output logic                                  rsp_status,
  output logic [NOU_ERR_CODE_WIDTH-1:0]         rsp_err_code,
  output logic [NOU_BUF_RM_WIDTH-1:0]           rsp_rm,
  output logic [$clog2(NREQ)-1:0]               rsp_src,
  output logic [RCNT_W-1:0]                     retire_cnt,
  output logic [ECNT_W-1:0]                     err_cnt
);

  localparam int unsigned IW = $clog2(NREQ);

  bu_rtr_state_e r_state, w_state_nxt;
  bu_rtr_rec_t   r_rec;
  bu_rtr_rec_t   w_rec [NREQ];
  logic [IW-1:0] r_ptr, r_src, w_ptr_nxt;
  logic [RCNT_W-1:0] r_rcnt;
  logic [ECNT_W-1:0] r_ecnt;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic            w_load, w_any, w_accept, w_xfer;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_rec[g].sid      = req_sid[g*NOU_SID_WIDTH +: NOU_SID_WIDTH];
    assign w_rec[g].rtype    = req_rtype[g*NOU_RSP_TYPE_ID_WIDTH +: NOU_RSP_TYPE_ID_WIDTH];
    assign w_rec[g].buf_id   = req_buf_id[g*NOU_BUF_ID_WIDTH +: NOU_BUF_ID_WIDTH];
    assign w_rec[g].status   = req_status[g];
    assign w_rec[g].err_code = req_err_code[g*NOU_ERR_CODE_WIDTH +: NOU_ERR_CODE_WIDTH];
    assign w_rec[g].rm       = req_rm[g*NOU_BUF_RM_WIDTH +: NOU_BUF_RM_WIDTH];
  end

  bu_rr_arb #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_arb (
    .req       (req_vld),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  // rstn gates load so no requester sees ready while the block is held in reset.
  assign w_load    = rstn & ((r_state == RS_EMPTY) | rsp_rdy);
  assign w_any     = |req_vld;
  assign w_accept  = w_load & w_any;
  assign w_xfer    = (r_state == RS_FULL) & rsp_rdy;
  assign req_rdy   = w_grant & {NREQ{w_load}};
  assign w_ptr_nxt = (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + IW'(1);

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = w_any ? RS_FULL : RS_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RS_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload, source and pointer only move on an accepted record.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rec <= '0;
      r_src <= '0;
      r_ptr <= '0;
    end else if (w_accept) begin
      r_rec <= w_rec[w_gidx];
      r_src <= w_gidx;
      r_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rcnt <= '0;
      r_ecnt <= '0;
    end else if (w_xfer) begin
      r_rcnt <= r_rcnt + RCNT_W'(1);
      if (r_rec.status && (r_ecnt != '1)) begin
        r_ecnt <= r_ecnt + ECNT_W'(1);
      end
    end
  end

  assign rsp_vld      = (r_state == RS_FULL);
  assign rsp_sid      = r_rec.sid;
  assign rsp_rtype    = r_rec.rtype;
  assign rsp_buf_id   = r_rec.buf_id;
  assign rsp_status   = r_rec.status;
  assign rsp_err_code = r_rec.err_code;
  assign rsp_rm       = r_rec.rm;
  assign rsp_src      = r_src;
  assign retire_cnt   = r_rcnt;
  assign err_cnt      = r_ecnt;

endmodule
